// File: rtl/uart_rx_if.sv
// Serial receive line and decoded-frame outputs of uart_rx.
// The receiver uses master; the line driver/consumer uses slave.
interface uart_rx_if;
  logic       RXD;
  logic       RX_DATA_EN;
  logic [9:0] RX_DATA_R;
  logic       RX_BUSY;

  modport master (input RXD, output RX_DATA_EN, output RX_DATA_R, output RX_BUSY);
  modport slave  (output RXD, input RX_DATA_EN, input RX_DATA_R, input RX_BUSY);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of an LSB-first frame with optional parity.
// Emits a one-clock RX_DATA_EN pulse with {frame_err, parity_err, byte}.
module uart_rx #(
  parameter int BAUD_DIV   = 868,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input logic       CLK,
  input logic       RST,
  uart_rx_if.master bus
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_T = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_T = CNT_W'(BAUD_DIV - 1);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic PEN = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       sh, sh_n;
  logic             perr, perr_n;
  logic [9:0]       data_r, data_n;
  logic             en, en_n;
  logic             rx_m, rx_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      perr   <= 1'b0;
      data_r <= '0;
      en     <= 1'b0;
    end else begin
      rx_m   <= bus.RXD;
      rx_s   <= rx_m;
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      perr   <= perr_n;
      data_r <= data_n;
      en     <= en_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    perr_n  = perr;
    data_n  = data_r;
    en_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_T) begin
          cnt_n = '0;
          // Start bit must still be low at its midpoint, else it was a glitch.
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
            perr_n  = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_T) begin
          cnt_n     = '0;
          sh_n[idx] = rx_s;
          if (idx == 3'd7) begin
            idx_n   = '0;
            state_n = PEN ? PARITY : STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt == FULL_T) begin
          cnt_n   = '0;
          perr_n  = ((^sh) ^ rx_s) != ODD;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_T) begin
          cnt_n   = '0;
          data_n  = {~rx_s, perr & PEN, sh};
          en_n    = 1'b1;
          // A low stop bit may be a break; wait for the line to recover.
          state_n = rx_s ? IDLE : WAIT_HIGH;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.RX_DATA_EN = en;
  assign bus.RX_DATA_R  = data_r;
  assign bus.RX_BUSY    = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (BAUD_DIV=16, even parity) against a
// frame-level reference model.
module tb_uart_rx;
  localparam int B   = 16;
  localparam int PEN = 1;
  localparam logic ODD = 1'b0;
  localparam int LAT = B / 2 + (9 + PEN) * B + 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [9:0] got_q[$];
  int         got_t[$];

  uart_rx_if rif ();

  uart_rx #(.BAUD_DIV(B), .PARITY_EN(PEN), .PARITY_ODD(0)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(rif)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (rif.RX_DATA_EN) begin
      got_q.push_back(rif.RX_DATA_R);
      got_t.push_back(cyc);
    end
  end

  task automatic drive(input logic v, input int n);
    rif.RXD = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic ideal_parity(input logic [7:0] b);
    return (^b) ^ ODD;
  endfunction

  function automatic logic [9:0] model(input logic [7:0] b, input logic pbit, input logic stopv);
    return {~stopv, (PEN != 0) && (pbit != ideal_parity(b)), b};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stopv);
    drive(1'b0, B);
    for (int i = 0; i < 8; i++) drive(b[i], B);
    if (PEN != 0) drive(pbit, B);
    drive(stopv, B);
  endtask

  task automatic clear_q();
    got_q.delete();
    got_t.delete();
  endtask

  task automatic test_reset();
    rif.RXD = 1'b1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (rif.RX_DATA_R !== 10'h000) begin
      errors++; $display("FAIL reset_data got %h exp %h", rif.RX_DATA_R, 10'h000);
    end
    checks++;
    if (rif.RX_DATA_EN !== 1'b0) begin
      errors++; $display("FAIL reset_en got %b exp 0", rif.RX_DATA_EN);
    end
    checks++;
    if (rif.RX_BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", rif.RX_BUSY);
    end
    RST = 1'b0;
    drive(1'b1, 4);
  endtask

  task automatic test_errors();
    logic [9:0] exp_v [4];
    logic [7:0] b;
    logic       pb, sv;
    int         t0;
    b = 8'h41;
    for (int k = 0; k < 4; k++) begin
      pb = ideal_parity(b) ^ k[0];
      sv = ~k[1];
      exp_v[k] = model(b, pb, sv);
      clear_q();
      t0 = cyc;
      send_frame(b, pb, sv);
      drive(1'b1, 2 * B);
      checks++;
      if (got_q.size() != 1) begin
        errors++; $display("FAIL err%0d_count got %0d exp 1", k, got_q.size());
      end else begin
        checks++;
        if (got_q[0] !== exp_v[k]) begin
          errors++; $display("FAIL err%0d_data got %h exp %h", k, got_q[0], exp_v[k]);
        end
        checks++;
        if (got_t[0] - t0 < LAT - 1 || got_t[0] - t0 > LAT + 1) begin
          errors++; $display("FAIL err%0d_latency got %0d exp %0d", k, got_t[0] - t0, LAT);
        end
      end
      checks++;
      if (rif.RX_BUSY !== 1'b0) begin
        errors++; $display("FAIL err%0d_busy got %b exp 0", k, rif.RX_BUSY);
      end
    end
    drive(1'b1, 3 * B);
    checks++;
    if (rif.RX_DATA_R !== exp_v[3]) begin
      errors++; $display("FAIL hold_data got %h exp %h", rif.RX_DATA_R, exp_v[3]);
    end
  endtask

  task automatic test_glitch();
    clear_q();
    drive(1'b0, 4);
    checks++;
    if (rif.RX_BUSY !== 1'b1) begin
      errors++; $display("FAIL glitch_busy_hi got %b exp 1", rif.RX_BUSY);
    end
    drive(1'b1, B / 2 + 3 - 4);
    checks++;
    if (rif.RX_BUSY !== 1'b0) begin
      errors++; $display("FAIL glitch_idle got %b exp 0", rif.RX_BUSY);
    end
    drive(1'b1, 12 * B);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL glitch_pulses got %0d exp 0", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'h0D, ideal_parity(8'h0D), 1'b1);
    send_frame(8'h0A, ideal_parity(8'h0A), 1'b1);
    drive(1'b1, 2 * B);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL b2b_count got %0d exp 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 10'h00D) begin
        errors++; $display("FAIL b2b_first got %h exp %h", got_q[0], 10'h00D);
      end
      checks++;
      if (got_q[1] !== 10'h00A) begin
        errors++; $display("FAIL b2b_second got %h exp %h", got_q[1], 10'h00A);
      end
      checks++;
      if (got_t[1] - got_t[0] != 11 * B) begin
        errors++; $display("FAIL b2b_spacing got %0d exp %0d", got_t[1] - got_t[0], 11 * B);
      end
    end
  endtask

  task automatic test_break();
    clear_q();
    drive(1'b0, 40 * B);
    drive(1'b1, 3 * B);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL break_count got %0d exp 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 10'h200) begin
        errors++; $display("FAIL break_data got %h exp %h", got_q[0], 10'h200);
      end
    end
    clear_q();
    send_frame(8'h30, ideal_parity(8'h30), 1'b1);
    drive(1'b1, 2 * B);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL after_break_count got %0d exp 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 10'h030) begin
        errors++; $display("FAIL after_break_data got %h exp %h", got_q[0], 10'h030);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    drive(1'b0, B);
    drive(1'b1, B / 2 + 2);
    RST = 1'b1;
    rif.RXD = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (rif.RX_DATA_R !== 10'h000) begin
      errors++; $display("FAIL midrst_data got %h exp %h", rif.RX_DATA_R, 10'h000);
    end
    checks++;
    if (rif.RX_BUSY !== 1'b0) begin
      errors++; $display("FAIL midrst_busy got %b exp 0", rif.RX_BUSY);
    end
    RST = 1'b0;
    drive(1'b1, 14 * B);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL midrst_pulses got %0d exp 0", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [9:0] exp_q[$];
    logic [7:0] b;
    logic       pb, sv;
    int         gap;
    clear_q();
    for (int i = 0; i < 24; i++) begin
      b   = 8'($urandom);
      pb  = ideal_parity(b) ^ ($urandom_range(0, 3) == 0);
      sv  = ($urandom_range(0, 3) != 0);
      gap = sv ? int'($urandom_range(0, 20)) : B + int'($urandom_range(0, 20));
      exp_q.push_back(model(b, pb, sv));
      send_frame(b, pb, sv);
      if (!sv) drive(1'b1, gap);
      else if (gap > 0) drive(1'b1, gap);
    end
    drive(1'b1, 3 * B);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rif.RXD = 1'b1;
    @(posedge CLK);
    #1;
    test_reset();
    test_errors();
    test_glitch();
    test_back_to_back();
    test_break();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
